// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder slice, LSB first
// Optional subtract mode (port sub, a-b via ~b and carry-in 1) is built when SERIAL_SUB_EN is defined.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_out;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // The shared one-bit slice.
  assign {c_out, s} = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
  assign res_next   = {s, res_sh[WIDTH-1:1]};

  // res_sh[0] is shifted out on every step and never needed again.
  logic unused_res_lsb;
  assign unused_res_lsb = res_sh[0];

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: invert b and force the initial carry to 1.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_sh <= res_next;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= c_out;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= c_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
`ifdef SERIAL_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Stimulus only: one start pulse, then observe 12 edges (edge 1 is the accepting edge).
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                       output int busy_cycles, output int done_pulses, output int done_edge,
                       output logic [7:0] rsum, output logic rcout);
    busy_cycles = 0;
    done_pulses = 0;
    done_edge   = -1;
    rsum        = 'x;
    rcout       = 1'bx;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_pulses++;
        done_edge = e;
        rsum = sum;
        rcout = cout;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int bc, dp, de;
    logic [7:0] rs;
    logic rc;
    do_op(8'h01, 8'h00, 1'b0, bc, dp, de, rs, rc);
    n_cmp++; if (bc != 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    n_cmp++; if (dp != 1) begin n_bad++; $display("FAIL basic_done_pulses got %0d want 1", dp); end
    n_cmp++; if (de != 9) begin n_bad++; $display("FAIL basic_done_edge got %0d want 9", de); end
    n_cmp++; if (rs !== 8'h01) begin n_bad++; $display("FAIL basic_sum got %h want 01", rs); end
    n_cmp++; if (rc !== 1'b0) begin n_bad++; $display("FAIL basic_cout got %b want 0", rc); end
  endtask

  task automatic test_carry;
    int bc, dp, de;
    logic [7:0] rs;
    logic rc;
    do_op(8'hFF, 8'h01, 1'b0, bc, dp, de, rs, rc);
    n_cmp++; if (rs !== 8'h00 || rc !== 1'b1) begin n_bad++; $display("FAIL carry_ff01 got %b/%h want 1/00", rc, rs); end
    do_op(8'h3C, 8'h0F, 1'b1, bc, dp, de, rs, rc);
    n_cmp++; if (rs !== 8'h4C || rc !== 1'b0) begin n_bad++; $display("FAIL carry_3c0f got %b/%h want 0/4c", rc, rs); end
    // Result must hold in IDLE while operand inputs wander.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (sum !== 8'h4C || cout !== 1'b0) begin n_bad++; $display("FAIL hold_idle got %b/%h want 0/4c", cout, sum); end
    // Accept must not clear the previous result.
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (sum !== 8'h4C || busy !== 1'b1) begin n_bad++; $display("FAIL hold_accept got busy=%b sum=%h want busy=1 sum=4c", busy, sum); end
    repeat (10) @(negedge clk);
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b1) begin n_bad++; $display("FAIL carry_a55a got %b/%h want 1/00", cout, sum); end
  endtask

  task automatic test_ignore;
    int dp;
    dp = 0;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 2; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dp++;
      // e=4 is RUN cycle 3, e=9 is the DONE cycle.
      if (e == 4 || e == 9) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (e == 5 || e == 10) start = 1'b0;
    end
    n_cmp++; if (dp != 1) begin n_bad++; $display("FAIL ignore_done_pulses got %0d want 1", dp); end
    n_cmp++; if (sum !== 8'h10 || cout !== 1'b0) begin n_bad++; $display("FAIL ignore_result got %b/%h want 0/10", cout, sum); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_async_reset;
    int bc, dp, de;
    logic [7:0] rs;
    logic rc;
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy got %b want 0", busy); end
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL async_outputs got done=%b cout=%b sum=%h want 0/0/00", done, cout, sum); end
    @(negedge clk);
    rst = 1'b0;
    dp = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dp++;
    end
    n_cmp++; if (dp != 0) begin n_bad++; $display("FAIL async_no_done got %0d want 0", dp); end
    do_op(8'h03, 8'h04, 1'b0, bc, dp, de, rs, rc);
    n_cmp++; if (rs !== 8'h07 || rc !== 1'b0 || dp != 1) begin n_bad++; $display("FAIL async_after_op got %b/%h pulses=%0d want 0/07 pulses=1", rc, rs, dp); end
  endtask

  task automatic test_back_to_back;
    int edges[$];
    int bad_res;
    bad_res = 0;
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        edges.push_back(e);
        if (sum !== 8'h80 || cout !== 1'b0) bad_res++;
      end
    end
    start = 1'b0;
    n_cmp++; if (edges.size() != 3) begin n_bad++; $display("FAIL b2b_pulses got %0d want 3", edges.size()); end
    n_cmp++; if (bad_res != 0) begin n_bad++; $display("FAIL b2b_results got %0d bad want 0", bad_res); end
    if (edges.size() >= 2) begin
      n_cmp++; if (edges[1] - edges[0] != 10) begin n_bad++; $display("FAIL b2b_period got %0d want 10", edges[1] - edges[0]); end
    end
    repeat (12) @(negedge clk);
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub;
    int bc, dp, de;
    logic [7:0] rs;
    logic rc;
    sub = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, bc, dp, de, rs, rc);
    n_cmp++; if (rs !== 8'h0F || rc !== 1'b1) begin n_bad++; $display("FAIL sub_10_01 got %b/%h want 1/0f", rc, rs); end
    do_op(8'h01, 8'h02, 1'b0, bc, dp, de, rs, rc);
    n_cmp++; if (rs !== 8'hFF || rc !== 1'b0) begin n_bad++; $display("FAIL sub_01_02 got %b/%h want 0/ff", rc, rs); end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore();
    test_async_reset();
    test_back_to_back();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
